// File: rtl/multiplicador_pkg.sv
// -----------------------------------------------------------------------------
// multiplicador_pkg
// Shared widths, latency bound and FSM state encoding for the sequential
// 16x16 shift-and-add multiplier (multiplicador + multiplicador_ctrl).
// -----------------------------------------------------------------------------
package multiplicador_pkg;

    localparam int unsigned OPW     = 16;  // operand width
    localparam int unsigned PRODW   = 32;  // product width
    localparam int unsigned MAX_LAT = 34;  // worst-case occupancy, load to done

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t CHECK = 2'd1;
    localparam state_t SHIFT = 2'd2;
    localparam state_t DONE  = 2'd3;

endpackage

// File: rtl/multiplicador_ctrl.sv
// -----------------------------------------------------------------------------
// multiplicador_ctrl
// Add/shift control unit: Moore FSM plus the 4-bit shift counter K.
// Optional macro: MULTIPLICADOR_ASSERT_EN compiles in a K-wrap check.
//
// Ports:
//   i_clk     clock, rising edge
//   i_reset   synchronous active-high reset
//   i_st      start request (sampled only in IDLE)
//   i_acc0    current multiplier LSB, ACC[0]
//   o_load    load operands into the datapath
//   o_ad      add MCAND into ACC[32:16]
//   o_sh      shift ACC right by one
//   o_idle    FSM in IDLE
//   o_done    FSM in DONE (one cycle)
// -----------------------------------------------------------------------------
module multiplicador_ctrl
    import multiplicador_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_st,
    input  logic i_acc0,
    output logic o_load,
    output logic o_ad,
    output logic o_sh,
    output logic o_idle,
    output logic o_done
);

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_k;
    logic       w_k;

    // Last of the 16 shifts happens while K == 15.
    assign w_k = (r_k == 4'd15);

    always_comb begin
        w_state_next = r_state;
        o_load       = 1'b0;
        o_ad         = 1'b0;
        o_sh         = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_st) begin
                    o_load       = 1'b1;
                    w_state_next = CHECK;
                end
            end
            CHECK: begin
                if (i_acc0) begin
                    o_ad         = 1'b1;
                    w_state_next = SHIFT;
                end else begin
                    o_sh         = 1'b1;
                    w_state_next = w_k ? DONE : CHECK;
                end
            end
            SHIFT: begin
                o_sh         = 1'b1;
                w_state_next = w_k ? DONE : CHECK;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_k     <= 4'd0;
        end else begin
            r_state <= w_state_next;
            if (o_load) begin
                r_k <= 4'd0;
            end else if (o_sh) begin
                r_k <= r_k + 4'd1;
            end
        end
    end

    assign o_idle = (r_state == IDLE);
    assign o_done = (r_state == DONE);

`ifdef MULTIPLICADOR_ASSERT_EN
    // K is zero whenever no operation is shifting: cleared at load and
    // wrapped back to zero by exactly the 16th shift.
    always @(posedge i_clk) begin
        if (!i_reset && (r_state != CHECK) && (r_state != SHIFT)) begin
            assert (r_k == 4'd0)
            else $error("multiplicador_ctrl: K=%0d outside CHECK/SHIFT", r_k);
        end
    end
`endif

endmodule

// File: rtl/multiplicador.sv
// -----------------------------------------------------------------------------
// multiplicador
// Sequential 16x16 unsigned shift-and-add multiplier. Holds the ACC/MCAND
// datapath and the adder; sequencing comes from multiplicador_ctrl.
// Optional macro: MULTIPLICADOR_ASSERT_EN compiles in simulation checks on
// the result, Idle/Done exclusivity and load-to-done latency.
//
// Ports:
//   Clk            clock, rising edge
//   Reset          synchronous active-high reset
//   St             start request, sampled in IDLE
//   Multiplicando  16-bit multiplicand, captured at load
//   Multiplicador  16-bit multiplier, captured at load
//   Produto        32-bit product (ACC[31:0]), final when Done
//   Idle           high while idle
//   Done           one-cycle completion pulse
// -----------------------------------------------------------------------------
module multiplicador
    import multiplicador_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             St,
    input  logic [OPW-1:0]   Multiplicando,
    input  logic [OPW-1:0]   Multiplicador,
    output logic [PRODW-1:0] Produto,
    output logic             Idle,
    output logic             Done
);

    // ACC[32] catches the add carry; the following shift pulls it down.
    logic [PRODW:0] r_acc;
    logic [OPW-1:0] r_mcand;
    logic [OPW:0]   w_soma;
    logic           w_load;
    logic           w_ad;
    logic           w_sh;

    assign w_soma = {1'b0, r_acc[PRODW-1:OPW]} + {1'b0, r_mcand};

    multiplicador_ctrl u_ctrl (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_st    (St),
        .i_acc0  (r_acc[0]),
        .o_load  (w_load),
        .o_ad    (w_ad),
        .o_sh    (w_sh),
        .o_idle  (Idle),
        .o_done  (Done)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_acc   <= '0;
            r_mcand <= '0;
        end else if (w_load) begin
            r_acc   <= {{(OPW+1){1'b0}}, Multiplicador};
            r_mcand <= Multiplicando;
        end else if (w_ad) begin
            r_acc[PRODW:OPW] <= w_soma;
        end else if (w_sh) begin
            r_acc <= {1'b0, r_acc[PRODW:1]};
        end
    end

    assign Produto = r_acc[PRODW-1:0];

`ifdef MULTIPLICADOR_ASSERT_EN
    logic [OPW-1:0] r_chk_mcand;
    logic [OPW-1:0] r_chk_mplier;
    logic [5:0]     r_chk_lat;

    always @(posedge Clk) begin
        if (Reset) begin
            r_chk_mcand  <= '0;
            r_chk_mplier <= '0;
            r_chk_lat    <= '0;
        end else begin
            if (w_load) begin
                r_chk_mcand  <= Multiplicando;
                r_chk_mplier <= Multiplicador;
                r_chk_lat    <= 6'd1;
            end else if (!Idle && !Done) begin
                r_chk_lat <= r_chk_lat + 6'd1;
            end
            assert (!(Idle && Done))
            else $error("multiplicador: Idle and Done both high");
            if (Done) begin
                assert (Produto == (PRODW'(r_chk_mcand) * PRODW'(r_chk_mplier)))
                else $error("multiplicador: product %h for %h*%h",
                            Produto, r_chk_mcand, r_chk_mplier);
                assert (32'(r_chk_lat) < MAX_LAT)
                else $error("multiplicador: DONE reached %0d cycles after load",
                            r_chk_lat);
            end
        end
    end
`endif

endmodule

// File: tb/tb_multiplicador.sv
// -----------------------------------------------------------------------------
// tb_multiplicador
// Directed self-checking bench for the multiplicador shift-and-add multiplier.
// -----------------------------------------------------------------------------
module tb_multiplicador;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        St = 1'b0;
    logic [15:0] Multiplicando = '0;
    logic [15:0] Multiplicador = '0;
    logic [31:0] Produto;
    logic        Idle;
    logic        Done;

    int checks = 0;
    int errors = 0;

    multiplicador dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .St            (St),
        .Multiplicando (Multiplicando),
        .Multiplicador (Multiplicador),
        .Produto       (Produto),
        .Idle          (Idle),
        .Done          (Done)
    );

    always #5 Clk = ~Clk;

    // Advance one edge; inputs and samples both live 1 time unit after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One pulsed-St operation; operands are scrambled right after load to
    // show they are not re-sampled mid-operation.
    task automatic run_op(input string tag, input logic [15:0] mcand,
                          input logic [15:0] mplier, input logic [31:0] exp_prod,
                          input int exp_edges);
        int  edges;
        bit  seen;
        bit  overlap;
        Multiplicando = mcand;
        Multiplicador = mplier;
        St = 1'b1;
        tick();  // load edge
        St = 1'b0;
        Multiplicando = ~mcand;
        Multiplicador = ~mplier;
        edges   = 0;
        seen    = 1'b0;
        overlap = 1'b0;
        while (!seen && edges < 40) begin
            tick();
            edges++;
            if (Idle && Done) overlap = 1'b1;
            if (Done) seen = 1'b1;
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " done_edges"}, edges, exp_edges);
        check({tag, " produto"}, Produto, exp_prod);
        check({tag, " no_overlap"}, 32'(overlap), 32'd0);
        tick();
        check({tag, " idle_after"}, {30'd0, Idle, Done}, 32'h2);
        tick();
        check({tag, " produto_held"}, Produto, exp_prod);
    endtask

    initial begin
        int          edges;
        int          dones;
        bit          overlap;
        logic [31:0] exp_prod;
        logic [15:0] m;

        // Reset with St low
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("reset idle/done", {30'd0, Idle, Done}, 32'h2);
        check("reset produto", Produto, 32'd0);
        repeat (3) tick();
        check("stay idle", {30'd0, Idle, Done}, 32'h2);

        // popcount(5)=2 -> 18 edges
        run_op("3x5", 16'd3, 16'd5, 32'd15, 18);
        run_op("5x3", 16'd5, 16'd3, 32'd15, 18);
        run_op("ffffxffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 32);
        run_op("ffffx0", 16'hFFFF, 16'h0000, 32'd0, 16);
        run_op("1234x10", 16'h1234, 16'h0010, 32'h00012340, 17);
        run_op("12x8001", 16'd12, 16'h8001, 32'h0006000C, 18);

        // Reset during cycle 10 of 65535x65535
        Multiplicando = 16'hFFFF;
        Multiplicador = 16'hFFFF;
        St = 1'b1;
        tick();
        St = 1'b0;
        repeat (9) tick();
        check("midop busy", {31'd0, Idle}, 32'd0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("midop reset idle/done", {30'd0, Idle, Done}, 32'h2);
        check("midop reset produto", Produto, 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Done || !Idle) dones++;
        end
        check("midop no done", dones, 0);

        // St held high, multiplicand 65535, multiplier swept in steps of 771
        Multiplicando = 16'hFFFF;
        St = 1'b1;
        dones    = 0;
        overlap  = 1'b0;
        exp_prod = '0;
        for (int v = 0; v <= 65535; v += 771) begin
            m = 16'(v);
            Multiplicador = m;
            for (int c = 0; c < 40; c++) begin
                if (Idle) exp_prod = 32'(m) * 32'd65535;  // loads at this edge
                tick();
                if (Idle && Done) overlap = 1'b1;
                if (Done) begin
                    dones++;
                    check("sweep produto", Produto, exp_prod);
                end
            end
        end
        St = 1'b0;
        check("sweep done count", 32'(dones >= 86), 32'd1);
        check("sweep no_overlap", 32'(overlap), 32'd0);

        // Drain the operation still in flight
        edges = 0;
        while (!Idle && edges < 40) begin
            tick();
            edges++;
        end
        check("final idle", {31'd0, Idle}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
